// File: rtl/uart_rx_fifo_n.sv
// uart_rx_fifo_n
// First-word-fall-through receive buffer between the UART receiver and the UDR
// read port. Each entry carries the character plus its FE/PE flags and a sticky
// DOR flag that marks the last character stored before an overrun.
module uart_rx_fifo_n #(
  parameter int DATA_W = 9,
  parameter int DEPTH  = 4,
  parameter int AW     = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_flush,
  input  logic              i_wr_valid,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_wr_fe,
  input  logic              i_wr_pe,
  input  logic              i_rd,
  output logic [DATA_W-1:0] o_udr,
  output logic              o_rxc,
  output logic              o_fe,
  output logic              o_pe,
  output logic              o_dor,
  output logic              o_space,
  output logic [AW:0]       o_level
);

  localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

  // Character storage is left unreset; only the per-entry flags are cleared.
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  fe_reg;
  logic [DEPTH-1:0]  pe_reg;
  logic [DEPTH-1:0]  dor_reg;

  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     wr_ptr_next;
  logic [AW-1:0]     rd_ptr_reg;
  logic [AW-1:0]     rd_ptr_next;
  logic [AW-1:0]     newest_ptr;
  logic [AW:0]       level_reg;
  logic [AW:0]       level_next;

  logic              empty;
  logic              full;
  logic              do_wr;
  logic              do_rd;
  logic              overrun;

  // Decode the accepted operations for this cycle; flush suppresses them all.
  always_comb begin
    empty      = (level_reg == '0);
    full       = (level_reg == FULL_LEVEL);
    // A read on a full buffer frees the slot the incoming character needs.
    do_wr      = i_wr_valid & (~full | i_rd) & ~i_flush;
    // A read on an empty buffer is ignored, even when a write lands alongside it.
    do_rd      = i_rd & ~empty & ~i_flush;
    overrun    = i_wr_valid & full & ~i_rd & ~i_flush;
    // When full, wr_ptr has wrapped onto rd_ptr, so the newest entry is one behind.
    newest_ptr = wr_ptr_reg - 1'b1;
  end

  // Pointer and level next-state; the power-of-two depth gives the wrap for free.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    level_next  = level_reg;
    if (i_flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      level_next  = '0;
    end else begin
      if (do_wr) begin
        wr_ptr_next = wr_ptr_reg + 1'b1;
      end
      if (do_rd) begin
        rd_ptr_next = rd_ptr_reg + 1'b1;
      end
      case ({do_wr, do_rd})
        2'b10:   level_next = level_reg + 1'b1;
        2'b01:   level_next = level_reg - 1'b1;
        default: level_next = level_reg;
      endcase
    end
  end

  // Pointer and level registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      level_reg  <= level_next;
    end
  end

  // Character storage write port.
  always_ff @(posedge i_clk) begin
    if (do_wr) begin
      mem[wr_ptr_reg] <= i_wr_data;
    end
  end

  // Per-entry status flags: loaded on write, DOR set on overrun of the newest entry.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_flags
      // Flag register for entry gi.
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          fe_reg[gi]  <= 1'b0;
          pe_reg[gi]  <= 1'b0;
          dor_reg[gi] <= 1'b0;
        end else if (i_flush) begin
          fe_reg[gi]  <= 1'b0;
          pe_reg[gi]  <= 1'b0;
          dor_reg[gi] <= 1'b0;
        end else if (do_wr && (wr_ptr_reg == AW'(gi))) begin
          fe_reg[gi]  <= i_wr_fe;
          pe_reg[gi]  <= i_wr_pe;
          dor_reg[gi] <= 1'b0;
        end else if (overrun && (newest_ptr == AW'(gi))) begin
          dor_reg[gi] <= 1'b1;
        end
      end
    end
  endgenerate

  // Head entry presented combinationally, forced to zero while empty.
  always_comb begin
    o_udr   = '0;
    o_fe    = 1'b0;
    o_pe    = 1'b0;
    o_dor   = 1'b0;
    o_rxc   = ~empty;
    o_space = ~full;
    o_level = level_reg;
    if (!empty) begin
      o_udr = mem[rd_ptr_reg];
      o_fe  = fe_reg[rd_ptr_reg];
      o_pe  = pe_reg[rd_ptr_reg];
      o_dor = dor_reg[rd_ptr_reg];
    end
  end

endmodule
